calc_alu_seq: RTL

CALC_ALU_SEQ -- requirements
Module: calc_alu_seq

---
 rtl/calc_alu_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: calculator ALU with digit entry, pending-operation apply and a sticky error state.
// Define CALC_MUL_EN to build the W-cycle shift-add multiplier; without it operation 11 raises an error.
module calc_alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_ALU,
  input  logic         cmd_valid,
  input  logic [3:0]   digit,
  input  logic [1:0]   operation,
  output logic [W-1:0] value,
  output logic         show_aux,
  output logic         full_AUX,
  output logic         full_ACC,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, EXEC, MUL_STEP, MUL_WB, ERROR} state_t;

  localparam logic [1:0]   OP_NONE    = 2'b00;
  localparam logic [1:0]   OP_ADD     = 2'b01;
  localparam logic [1:0]   OP_SUB     = 2'b10;
  localparam logic [1:0]   OP_MUL     = 2'b11;
  localparam logic [3:0]   NO_DIGIT   = 4'b1101;
  localparam logic [63:0]  AUX_LIM_64 = ((64'd1 << W) - 64'd10) / 64'd10;
  localparam logic [W-1:0] AUX_LIM    = AUX_LIM_64[W-1:0];

  state_t       state, state_nx;
  logic [W-1:0] acc, aux;
  logic [1:0]   pend_op, new_op;
  logic         is_digit, is_op;
  logic [W:0]   sum;
  logic [W-1:0] exec_val;
  logic         exec_err;
  logic         last_step;
  logic         mul_err;

  assign full_AUX = aux > AUX_LIM;
  assign value    = show_aux ? aux : acc;
  assign busy     = state != IDLE;
  assign is_digit = cmd_valid && (state == IDLE) && (digit <= 4'd9) && (operation == OP_NONE);
  assign is_op    = cmd_valid && (state == IDLE) && (digit == NO_DIGIT) && (operation != OP_NONE);
  assign sum      = {1'b0, acc} + {1'b0, aux};

  always_comb begin
    exec_val = aux;
    exec_err = 1'b0;
    case (pend_op)
      OP_ADD: begin
        exec_val = sum[W-1:0];
        exec_err = sum[W];
      end
      OP_SUB: begin
        exec_val = acc - aux;
        exec_err = aux > acc;
      end
      OP_MUL:  exec_err = 1'b1;
      default: exec_val = aux;
    endcase
`ifndef CALC_MUL_EN
    // Without the multiplier, requesting a multiply is itself the error.
    if (new_op == OP_MUL) exec_err = 1'b1;
`endif
  end

`ifdef CALC_MUL_EN
  logic [2*W-1:0] prod, mcand;
  logic [W-1:0]   mplier;
  logic [5:0]     step_cnt;

  assign last_step = step_cnt == 6'(W - 1);
  assign mul_err   = |prod[2*W-1:W];

  // Operands are captured on the accepting edge; acc/aux cannot change while busy.
  always_ff @(posedge clk) begin
    if (rst || clear_ALU) begin
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      step_cnt <= '0;
    end else if (is_op) begin
      prod     <= '0;
      mcand    <= {{W{1'b0}}, acc};
      mplier   <= aux;
      step_cnt <= '0;
    end else if (state == MUL_STEP) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      step_cnt <= step_cnt + 6'd1;
    end
  end
`else
  assign last_step = 1'b0;
  assign mul_err   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (is_op) begin
`ifdef CALC_MUL_EN
          state_nx = (pend_op == OP_MUL) ? MUL_STEP : EXEC;
`else
          state_nx = EXEC;
`endif
        end
      end
      EXEC:     state_nx = exec_err ? ERROR : IDLE;
      MUL_STEP: if (last_step) state_nx = MUL_WB;
      MUL_WB:   state_nx = mul_err ? ERROR : IDLE;
      ERROR:    state_nx = ERROR;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear_ALU) state <= IDLE;
    else                  state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_ALU) begin
      acc      <= '0;
      aux      <= '0;
      pend_op  <= OP_NONE;
      new_op   <= OP_NONE;
      show_aux <= 1'b0;
      full_ACC <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_digit && !full_AUX) begin
            aux      <= aux * W'(10) + W'(digit);
            show_aux <= 1'b1;
            done     <= 1'b1;
          end
          if (is_op) new_op <= operation;
        end
        EXEC: begin
          done     <= 1'b1;
          show_aux <= 1'b0;
          if (exec_err) begin
            full_ACC <= 1'b1;
          end else begin
            acc     <= exec_val;
            pend_op <= new_op;
            aux     <= '0;
          end
        end
`ifdef CALC_MUL_EN
        MUL_WB: begin
          done     <= 1'b1;
          show_aux <= 1'b0;
          if (mul_err) begin
            full_ACC <= 1'b1;
          end else begin
            acc     <= prod[W-1:0];
            pend_op <= new_op;
            aux     <= '0;
          end
        end
`endif
        default: done <= 1'b0;
      endcase
    end
  end
endmodule
